// File: rtl/dv_test_status_pkg.sv
// Shared types and helpers for the test-status controller.
// State encoding, error-id width helper and the watchdog timeout code.
package dv_test_status_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_DRAIN   = 3'd2,
    ST_REPORT  = 3'd3,
    ST_HALT    = 3'd4
  } state_e;

  // Width of err_id: must hold 0..num_req (num_req is the timeout code).
  function automatic int unsigned id_width(input int unsigned num_req);
    return $clog2(num_req + 1);
  endfunction

  function automatic int unsigned timeout_code(input int unsigned num_req);
    return num_req;
  endfunction

endpackage

// File: rtl/dv_rr_arb.sv
// Round-robin arbiter: combinational one-hot grant, pointer moves past the
// granted index when advance_i is high. Pointer resets to 0.
module dv_rr_arb #(
  parameter int unsigned N = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [N-1:0] req_i,
  input  logic         advance_i,
  output logic [N-1:0] gnt_o
);

  localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1;

  logic [PtrW-1:0] ptr_q, ptr_d;
  logic            found;

  // Search from the pointer upwards, then wrap to the indices below it.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && req_i[i] && (PtrW'(i) >= ptr_q)) begin
        gnt_o[i] = 1'b1;
        found    = 1'b1;
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && req_i[i] && (PtrW'(i) < ptr_q)) begin
        gnt_o[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (gnt_o[i]) begin
          ptr_d = (i == N - 1) ? '0 : PtrW'(i + 1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/dv_test_status_ctrl.sv
// Collects per-requester done/verdict requests, waits for a quiet drain
// window and issues one final pass/fail report. Optional watchdog: DV_TEST_STATUS_WDOG_EN.
module dv_test_status_ctrl
  import dv_test_status_pkg::*;
#(
  parameter int unsigned NumReq      = 4,
  parameter int unsigned DrainCycles = 16,
  parameter int unsigned WdogCycles  = 100000
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NumReq-1:0]           req_i,
  input  logic [NumReq-1:0]           fail_i,
  input  logic                        activity_i,
  output logic [NumReq-1:0]           ack_o,
  output logic                        status_valid_o,
  output logic                        status_pass_o,
  output logic [id_width(NumReq)-1:0] err_id_o,
  output logic                        busy_o
);

  localparam int unsigned IdW    = id_width(NumReq);
  localparam int unsigned DrainW = (DrainCycles > 1) ? $clog2(DrainCycles) : 1;
  localparam logic [DrainW-1:0] DrainLast = DrainW'(DrainCycles - 1);

  // Parameter range checks at elaboration time.
  if (NumReq < 1 || NumReq > 16) begin : g_bad_num_req
    $error("NumReq out of range 1..16");
  end
  if (DrainCycles < 1) begin : g_bad_drain
    $error("DrainCycles must be at least 1");
  end
  if (WdogCycles < 2) begin : g_bad_wdog
    $error("WdogCycles must be at least 2");
  end

  state_e             state_q, state_d;
  logic [NumReq-1:0]  done_q, done_d;
  logic               fail_q, fail_d;
  logic [IdW-1:0]     err_id_q, err_id_d;
  logic [DrainW-1:0]  drain_q, drain_d;
  logic               valid_q, valid_d;
  logic               pass_q, pass_d;
  logic               busy_q, busy_d;

  logic               active;
  logic               arb_en;
  logic [NumReq-1:0]  gnt;
  logic               gnt_any;
  logic               gnt_fail;
  logic [IdW-1:0]     gnt_idx;

`ifdef DV_TEST_STATUS_WDOG_EN
  localparam int unsigned WdogW = $clog2(WdogCycles);
  localparam logic [WdogW-1:0] WdogLast = WdogW'(WdogCycles - 1);
  logic [WdogW-1:0] wdog_q, wdog_d;
`endif

  assign active = (state_q == ST_IDLE) || (state_q == ST_COLLECT) ||
                  (state_q == ST_DRAIN);
  // Grants are suppressed while reset is asserted so ack_o reads 0 throughout.
  assign arb_en = rst_ni && active;

  dv_rr_arb #(
    .N(NumReq)
  ) u_arb (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .req_i    (req_i & {NumReq{arb_en}}),
    .advance_i(gnt_any),
    .gnt_o    (gnt)
  );

  assign gnt_any = |gnt;
  assign ack_o   = gnt;

  // A grant to an already-done requester counts as a failure with its own index.
  always_comb begin
    gnt_idx  = '0;
    gnt_fail = 1'b0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (gnt[i]) begin
        gnt_idx  = IdW'(i);
        gnt_fail = fail_i[i] | done_q[i];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    done_d   = done_q;
    fail_d   = fail_q;
    err_id_d = err_id_q;
    drain_d  = drain_q;
    valid_d  = 1'b0;
    pass_d   = pass_q;
`ifdef DV_TEST_STATUS_WDOG_EN
    wdog_d   = wdog_q;
`endif

    if (gnt_any) begin
      done_d = done_q | gnt;
      if (gnt_fail) begin
        fail_d = 1'b1;
        if (!fail_q) begin
          err_id_d = gnt_idx;
        end
      end
    end

    unique case (state_q)
      ST_IDLE, ST_COLLECT: begin
        if (&done_d) begin
          state_d = ST_DRAIN;
          drain_d = '0;
        end else if (gnt_any) begin
          state_d = ST_COLLECT;
        end
      end
      ST_DRAIN: begin
        if (activity_i) begin
          drain_d = '0;
        end else if (drain_q == DrainLast) begin
          state_d = ST_REPORT;
          valid_d = 1'b1;
          pass_d  = !fail_d;
        end else begin
          drain_d = drain_q + DrainW'(1);
        end
      end
      ST_REPORT: state_d = ST_HALT;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_IDLE;
    endcase

`ifdef DV_TEST_STATUS_WDOG_EN
    // Timeout wins over any other transition taken this cycle.
    if (active) begin
      wdog_d = wdog_q + WdogW'(1);
      if (wdog_d == WdogLast) begin
        state_d  = ST_REPORT;
        valid_d  = 1'b1;
        pass_d   = 1'b0;
        err_id_d = IdW'(timeout_code(NumReq));
      end
    end
`endif

    busy_d = (state_d == ST_COLLECT) || (state_d == ST_DRAIN);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      done_q   <= '0;
      fail_q   <= 1'b0;
      err_id_q <= '0;
      drain_q  <= '0;
      valid_q  <= 1'b0;
      pass_q   <= 1'b0;
      busy_q   <= 1'b0;
`ifdef DV_TEST_STATUS_WDOG_EN
      wdog_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      done_q   <= done_d;
      fail_q   <= fail_d;
      err_id_q <= err_id_d;
      drain_q  <= drain_d;
      valid_q  <= valid_d;
      pass_q   <= pass_d;
      busy_q   <= busy_d;
`ifdef DV_TEST_STATUS_WDOG_EN
      wdog_q   <= wdog_d;
`endif
    end
  end

  assign status_valid_o = valid_q;
  assign status_pass_o  = pass_q;
  assign err_id_o       = err_id_q;
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_dv_test_status_ctrl.sv
// Directed bench for dv_test_status_ctrl (NumReq=4, DrainCycles=16).
// Cycle k is the k-th clock after reset release; inputs change on negedge.
module tb_dv_test_status_ctrl;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  logic [3:0] req_i = '0;
  logic [3:0] fail_i = '0;
  logic       activity_i = 1'b0;
  logic [3:0] ack_o;
  logic       status_valid_o;
  logic       status_pass_o;
  logic [2:0] err_id_o;
  logic       busy_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [3:0] ack_log[4];
  int         ack_cyc[4];
  int         n_acks;

  dv_test_status_ctrl #(
    .NumReq     (4),
    .DrainCycles(16),
    .WdogCycles (50)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .req_i         (req_i),
    .fail_i        (fail_i),
    .activity_i    (activity_i),
    .ack_o         (ack_o),
    .status_valid_o(status_valid_o),
    .status_pass_o (status_pass_o),
    .err_id_o      (err_id_o),
    .busy_o        (busy_o)
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(negedge clk);
    cyc = cyc + 1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    req_i = '0;
    fail_i = '0;
    activity_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    cyc = 0;
  endtask

  // All four requesters raise req at the current cycle and hold until acked.
  task automatic collect(input logic [3:0] fail_vec);
    logic [3:0] pending;
    pending = 4'hF;
    n_acks = 0;
    for (int i = 0; i < 4; i++) begin
      ack_log[i] = '0;
      ack_cyc[i] = -1;
    end
    fail_i = fail_vec;
    for (int k = 0; k < 8 && pending != 4'h0; k++) begin
      req_i = pending;
      #1;
      if (ack_o != 4'h0 && n_acks < 4) begin
        ack_log[n_acks] = ack_o;
        ack_cyc[n_acks] = cyc;
        n_acks = n_acks + 1;
      end
      pending = pending & ~ack_o;
      next_cycle();
    end
    req_i = '0;
    fail_i = '0;
  endtask

  // Returns the cycle of the status_valid_o pulse, or -1 after 200 cycles.
  task automatic wait_report(output int vcyc);
    vcyc = -1;
    for (int k = 0; k < 200; k++) begin
      #1;
      if (status_valid_o === 1'b1) begin
        vcyc = cyc;
        break;
      end
      next_cycle();
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    req_i = 4'hF;
    @(negedge clk);
    #1;
    checks++;
    if (ack_o !== 4'h0 || status_valid_o !== 1'b0 || status_pass_o !== 1'b0 ||
        err_id_o !== 3'd0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: ack=%b valid=%b pass=%b err=%0d busy=%b, want all 0",
               ack_o, status_valid_o, status_pass_o, err_id_o, busy_o);
    end
  endtask

  task automatic test_all_pass();
    int vcyc;
    int pulses;
    do_reset();
    collect(4'h0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ack_log[i] !== 4'(1 << i) || ack_cyc[i] != i) begin
        errors++;
        $display("FAIL pass_ack_order[%0d]: got %b at cycle %0d, want %b at cycle %0d",
                 i, ack_log[i], ack_cyc[i], 4'(1 << i), i);
      end
    end
    #1;
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("FAIL busy_in_drain: got %b, want 1", busy_o);
    end
    next_cycle();
    wait_report(vcyc);
    checks++;
    if (vcyc != 20 || status_pass_o !== 1'b1 || err_id_o !== 3'd0) begin
      errors++;
      $display("FAIL pass_report: cycle=%0d pass=%b err=%0d, want cycle=20 pass=1 err=0",
               vcyc, status_pass_o, err_id_o);
    end
    // HALT: requests and activity are ignored, verdict holds.
    next_cycle();
    req_i = 4'b0010;
    activity_i = 1'b1;
    #1;
    checks++;
    if (ack_o !== 4'h0 || status_valid_o !== 1'b0 || status_pass_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL halt_hold: ack=%b valid=%b pass=%b busy=%b, want 0000 0 1 0",
               ack_o, status_valid_o, status_pass_o, busy_o);
    end
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      next_cycle();
      #1;
      if (status_valid_o === 1'b1 || ack_o !== 4'h0) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL halt_quiet: got %0d valid/ack cycles, want 0", pulses);
    end
    req_i = '0;
    activity_i = 1'b0;
  endtask

  task automatic test_fail_order();
    int vcyc;
    do_reset();
    collect(4'b0110);
    checks++;
    if (ack_log[1] !== 4'b0010 || ack_log[2] !== 4'b0100) begin
      errors++;
      $display("FAIL fail_ack_order: got %b then %b, want 0010 then 0100", ack_log[1], ack_log[2]);
    end
    wait_report(vcyc);
    checks++;
    if (vcyc != 20 || status_pass_o !== 1'b0 || err_id_o !== 3'd1) begin
      errors++;
      $display("FAIL fail_report: cycle=%0d pass=%b err=%0d, want cycle=20 pass=0 err=1",
               vcyc, status_pass_o, err_id_o);
    end
  endtask

  task automatic test_activity();
    int vcyc;
    do_reset();
    collect(4'h0);
    // Drain count equals cyc-4; pulse activity at count 10.
    while (cyc < 14) next_cycle();
    activity_i = 1'b1;
    next_cycle();
    activity_i = 1'b0;
    wait_report(vcyc);
    checks++;
    if (vcyc != 31 || status_pass_o !== 1'b1) begin
      errors++;
      $display("FAIL activity_delay: cycle=%0d pass=%b, want cycle=31 pass=1", vcyc, status_pass_o);
    end
  endtask

  task automatic test_duplicate();
    int vcyc;
    do_reset();
    collect(4'h0);
    while (cyc < 6) next_cycle();
    req_i = 4'b1000;
    #1;
    checks++;
    if (ack_o !== 4'b1000) begin
      errors++;
      $display("FAIL dup_ack: got %b, want 1000", ack_o);
    end
    next_cycle();
    req_i = '0;
    wait_report(vcyc);
    checks++;
    if (vcyc != 20 || status_pass_o !== 1'b0 || err_id_o !== 3'd3) begin
      errors++;
      $display("FAIL dup_report: cycle=%0d pass=%b err=%0d, want cycle=20 pass=0 err=3",
               vcyc, status_pass_o, err_id_o);
    end
  endtask

  task automatic test_reset_mid_drain();
    int vcyc;
    do_reset();
    collect(4'b0100);
    while (cyc < 10) next_cycle();
    rst_ni = 1'b0;
    req_i = 4'b0101;
    #1;
    checks++;
    if (ack_o !== 4'h0 || status_valid_o !== 1'b0 || status_pass_o !== 1'b0 ||
        err_id_o !== 3'd0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_drain_reset: ack=%b valid=%b pass=%b err=%0d busy=%b, want all 0",
               ack_o, status_valid_o, status_pass_o, err_id_o, busy_o);
    end
    next_cycle();
    req_i = '0;
    next_cycle();
    rst_ni = 1'b1;
    cyc = 0;
    collect(4'h0);
    wait_report(vcyc);
    checks++;
    if (vcyc != 20 || status_pass_o !== 1'b1 || err_id_o !== 3'd0) begin
      errors++;
      $display("FAIL rerun_report: cycle=%0d pass=%b err=%0d, want cycle=20 pass=1 err=0",
               vcyc, status_pass_o, err_id_o);
    end
  endtask

  // Staggered requests: pointer wraps from 3 back to 0; first failure is index 3.
  task automatic test_back_to_back();
    int vcyc;
    logic [3:0] exp_ack[4];
    exp_ack[0] = 4'b0100;
    exp_ack[1] = 4'b1000;
    exp_ack[2] = 4'b0001;
    exp_ack[3] = 4'b0010;
    do_reset();
    fail_i = 4'b1001;
    req_i = 4'b0100;
    #1;
    checks++;
    if (ack_o !== exp_ack[0]) begin
      errors++;
      $display("FAIL rr_ack[0]: got %b, want %b", ack_o, exp_ack[0]);
    end
    next_cycle();
    req_i = 4'b1011;
    for (int i = 1; i < 4; i++) begin
      #1;
      checks++;
      if (ack_o !== exp_ack[i]) begin
        errors++;
        $display("FAIL rr_ack[%0d]: got %b, want %b", i, ack_o, exp_ack[i]);
      end
      next_cycle();
      req_i = req_i & ~exp_ack[i];
    end
    fail_i = '0;
    wait_report(vcyc);
    checks++;
    if (vcyc != 20 || status_pass_o !== 1'b0 || err_id_o !== 3'd3) begin
      errors++;
      $display("FAIL rr_report: cycle=%0d pass=%b err=%0d, want cycle=20 pass=0 err=3",
               vcyc, status_pass_o, err_id_o);
    end
  endtask

`ifdef DV_TEST_STATUS_WDOG_EN
  task automatic test_watchdog();
    int vcyc;
    int pulses;
    do_reset();
    req_i = 4'b1110;
    for (int k = 0; k < 3; k++) begin
      #1;
      req_i = req_i & ~ack_o;
      next_cycle();
    end
    req_i = '0;
    wait_report(vcyc);
    checks++;
    if (vcyc != 49 || status_pass_o !== 1'b0 || err_id_o !== 3'd4) begin
      errors++;
      $display("FAIL wdog_report: cycle=%0d pass=%b err=%0d, want cycle=49 pass=0 err=4",
               vcyc, status_pass_o, err_id_o);
    end
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      next_cycle();
      #1;
      if (status_valid_o === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL wdog_halt: got %0d extra pulses, want 0", pulses);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_all_pass();
    test_fail_order();
    test_activity();
    test_duplicate();
    test_reset_mid_drain();
    test_back_to_back();
`ifdef DV_TEST_STATUS_WDOG_EN
    test_watchdog();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/dv_test_status_ctrl.md
DV_TEST_STATUS_CTRL -- requirements
Module: dv_test_status_ctrl

Interface
REQ-001 Parameter NumReq, default 4: number of status requesters, range 1..16.
REQ-002 Parameter DrainCycles, default 16: quiet cycles required after the last done before reporting, minimum 1.
REQ-003 Parameter WdogCycles, default 100000: watchdog limit in cycles, used only when the watchdog is compiled in.
REQ-004 Port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005 Port rst_ni  input  1  asynchronous active-low reset.
REQ-006 Port req_i  input  NumReq  per-requester done request; held until acked.
REQ-007 Port fail_i  input  NumReq  per-requester verdict, qualified by req_i; 1 = failed.
REQ-008 Port activity_i  input  1  DUT/bench activity; any high cycle restarts the drain count.
REQ-009 Port ack_o  output  NumReq  one-hot grant; at most one bit high per cycle.
REQ-010 Port status_valid_o  output  1  single-cycle pulse when the final verdict is issued.
REQ-011 Port status_pass_o  output  1  final verdict, held from the report cycle until reset.
REQ-012 Port err_id_o  output  $clog2(NumReq+1)  first failing requester index; NumReq = watchdog timeout; 0 when passing.
REQ-013 Port busy_o  output  1  high in COLLECT and DRAIN.

Function
REQ-014 FSM states: IDLE, COLLECT, DRAIN, REPORT, HALT.
REQ-015 IDLE -> COLLECT on the first cycle any req_i bit is high; the grant is issued in that same cycle.
REQ-016 In IDLE/COLLECT, one pending request is acked per cycle, with round-robin arbitration starting at the index after the last grant (pointer 0 after reset).
REQ-017 Ack is combinational in the cycle of selection; the done mask and fail record update on the following edge.
REQ-018 Each granted fail_i=1 sets the fail flag; err_id_o latches only the first failing index granted, and later failures do not overwrite it.
REQ-019 A request from an already-done requester is acked and treated as a failure with its own index (duplicate-done error).
REQ-020 COLLECT -> DRAIN on the edge where the done mask becomes all ones; the drain counter loads 0.
REQ-021 In DRAIN, the counter increments on each cycle with activity_i=0 and clears to 0 on activity_i=1; DRAIN -> REPORT when the counter reaches DrainCycles-1 with activity_i=0.
REQ-022 A req_i seen in DRAIN is a duplicate: it is acked, the failure is recorded (REQ-019), and the state stays in DRAIN.
REQ-023 REPORT lasts exactly one cycle: status_valid_o=1 and status_pass_o = !fail flag; then unconditionally -> HALT.
REQ-024 HALT is terminal until reset: outputs hold, no acks, and req_i/activity_i are ignored.
REQ-025 With NumReq=1 the arbiter degenerates to a pass-through; timing is otherwise unchanged.

Reset
REQ-026 Reset asserted at any time, including mid-DRAIN, forces IDLE with ack_o=0, status_valid_o=0, status_pass_o=0, err_id_o=0, busy_o=0, and the done mask, fail flag, counters and RR pointer cleared.
REQ-027 Deassertion is used without an internal synchronizer; no output toggles in the first cycle after deassertion unless req_i is high.

Configuration
REQ-028 Macro DV_TEST_STATUS_WDOG_EN: when defined, a counter runs in IDLE/COLLECT/DRAIN. When it reaches WdogCycles-1, the FSM moves -> REPORT with pass=0 and err_id_o=NumReq, overriding any pending transition.
REQ-029 When DV_TEST_STATUS_WDOG_EN is undefined, no watchdog logic exists, WdogCycles is unused, and err_id_o never equals NumReq.

Structure
REQ-030 The state enum, the timeout code function (returns NumReq) and the id-width helper live in the shared dv_test_status_pkg.
REQ-031 Round-robin grant logic is a sub-module dv_rr_arb (parameter N; ports req, gnt one-hot, advance); the controller contains no other sub-modules.

Verification
REQ-032 NumReq=4: all req_i pass, simultaneous at cycle 0 -> acks 0,1,2,3 on consecutive cycles; status_valid_o 16 quiet cycles after the last mask update; pass=1, err_id_o=0.
REQ-033 Requesters 2 and 1 fail, acked in order 1 then 2 -> pass=0, err_id_o=1.
REQ-034 Drain with activity_i pulsed at drain count 10 -> report is delayed to 16 cycles after that pulse.
REQ-035 Requester 3 re-raises req_i after its ack, in DRAIN -> acked, pass=0, err_id_o=3.
REQ-036 Reset is asserted mid-DRAIN, then a clean pass run follows -> all outputs are 0 during reset; the second run reports pass=1.
REQ-037 DV_TEST_STATUS_WDOG_EN, WdogCycles=50, requester 0 never requests -> report at cycle 49 with pass=0 and err_id_o=4; then HALT, and no further status_valid_o pulses.
